guess_game_ctrl: RTL

- Control FSM for the number-guessing datapath (8-bit `actual` register with increment enable, 4-bit guesses-remaining counter reset to 7, guess-vs-actual comparators).
- Seeds `actual` by free-running increments until the player's first Enter press.
- Sequences guess evaluation, decrementing the remaining-guess count and latching hints.
- Detects win/lose and issues a datapath clear to start a new game.

---
 rtl/guess_game_ctrl_if.sv | 29 ++
 rtl/guess_game_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl_if.sv
// Player/datapath signal bundle seen by the guess-game controller.
// master = controller side, slave = datapath / button side.
interface guess_game_ctrl_if;
    logic       i_enter;
    logic       i_over;
    logic       i_under;
    logic       i_equal;
    logic       i_out_of_guesses;
    logic       o_inc_actual;
    logic       o_dec_guesses;
    logic       o_dp_clear;
    logic       o_hint_over;
    logic       o_hint_under;
    logic       o_win;
    logic       o_lose;
    logic [2:0] o_state;

    modport master (
        input  i_enter, i_over, i_under, i_equal, i_out_of_guesses,
        output o_inc_actual, o_dec_guesses, o_dp_clear, o_hint_over,
               o_hint_under, o_win, o_lose, o_state
    );

    modport slave (
        output i_enter, i_over, i_under, i_equal, i_out_of_guesses,
        input  o_inc_actual, o_dec_guesses, o_dp_clear, o_hint_over,
               o_hint_under, o_win, o_lose, o_state
    );
endinterface

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: debounced Enter press drives a seed/check/win/lose FSM.
// Press latency SYNC_STAGES+DEBOUNCE_CYCLES cycles; no backpressure, presses outside SEED/WAIT/WIN/LOSE are dropped.
module guess_game_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    guess_game_ctrl_if.master bus
);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        ST_SEED    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_DECWAIT = 3'd3,
        ST_WIN     = 3'd4,
        ST_LOSE    = 3'd5,
        ST_CLEAR   = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   armed_q;
    logic                   level;
    logic                   press;
    logic                   hint_over_q, hint_under_q;
    logic                   dp_clear_q;
    logic                   dec_guesses;

    assign level = sync_q[SYNC_STAGES-1];
    assign press = armed_q && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_enter};
            if (!level)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
            // Re-arm only once the button is seen released, so a held button gives one press.
            if (!level)
                armed_q <= 1'b1;
            else if (press)
                armed_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_SEED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        dec_guesses = 1'b0;
        case (state_q)
            ST_SEED:    if (press) state_d = ST_CHECK;
            ST_WAIT:    if (press) state_d = ST_CHECK;
            ST_CHECK: begin
                // Equality is judged before any decrement, so the last guess can still win.
                if (bus.i_equal) begin
                    state_d = ST_WIN;
                end else begin
                    state_d     = ST_DECWAIT;
                    dec_guesses = 1'b1;
                end
            end
            ST_DECWAIT: state_d = bus.i_out_of_guesses ? ST_LOSE : ST_WAIT;
            ST_WIN:     if (press) state_d = ST_CLEAR;
            ST_LOSE:    if (press) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_SEED;
            default:    state_d = ST_SEED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hint_over_q  <= 1'b0;
            hint_under_q <= 1'b0;
            dp_clear_q   <= 1'b0;
        end else begin
            dp_clear_q <= (state_d == ST_CLEAR);
            case (state_q)
                ST_CHECK: begin
                    if (bus.i_equal) begin
                        hint_over_q  <= 1'b0;
                        hint_under_q <= 1'b0;
                    end else begin
                        hint_over_q  <= bus.i_over;
                        hint_under_q <= bus.i_under && !bus.i_over;
                    end
                end
                ST_CLEAR, ST_ILLEGAL: begin
                    hint_over_q  <= 1'b0;
                    hint_under_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_inc_actual  = (state_q == ST_SEED);
    assign bus.o_dec_guesses = dec_guesses;
    assign bus.o_dp_clear    = dp_clear_q;
    assign bus.o_hint_over   = hint_over_q;
    assign bus.o_hint_under  = hint_under_q;
    assign bus.o_win         = (state_q == ST_WIN);
    assign bus.o_lose        = (state_q == ST_LOSE);
    assign bus.o_state       = state_q;
endmodule
